// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared payload widths and NOP constants for pipeline stage buffers
package pipe_pkg;
    localparam int NOP_INSN_W = 32;
    localparam logic [NOP_INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    // Per-boundary payload widths: PC+4 alongside the stage's own fields.
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 128;
    localparam int EX_MEM_W = 96;
    localparam int MEM_WB_W = 72;

    localparam logic [IF_ID_W-1:0] IF_ID_NOP = {32'h0, NOP_INSN};
endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-MOD counter with enable and synchronous clear
module wrap_counter #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] value
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= (value == W'(MOD - 1)) ? '0 : value + W'(1);
        end
    end
endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready circular buffer between two pipeline stages
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = IF_ID_W,
    parameter int                 DEPTH     = 2,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              push;
    logic              pop;

    // Ready is a function of occupancy only, so no combinational path from out_ready.
    assign in_ready  = (cnt < CNT_W'(DEPTH)) && !flush;
    assign out_valid = (cnt != '0) && !flush;
    assign out_data  = (cnt != '0) ? mem[rd_ptr] : NOP_VALUE;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    wrap_counter #(.MOD(DEPTH), .W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .en    (push),
        .value (wr_ptr)
    );

    wrap_counter #(.MOD(DEPTH), .W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .en    (pop),
        .value (rd_ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (push && !pop) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !push) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf at DEPTH 2, 3 and 1
module tb_pipe_stage_buf;
    localparam logic [15:0] NOP = 16'h0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;
    int          sel = 0;

    logic        iv [3];
    logic        orr [3];
    logic        fl [3];
    logic        rdy [3];
    logic        vld [3];
    logic [15:0] dat [3];
    logic [1:0]  cnt0, cnt2;
    logic [0:0]  cnt1;
    logic [1:0]  cnts [3];

    int          errors = 0;
    int          checks = 0;
    int          mcnt = 0;
    bit          acc;
    logic [15:0] q [$];
    int          dep [3] = '{2, 1, 3};

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            iv[k]  = in_valid && (sel == k);
            orr[k] = out_ready && (sel == k);
            fl[k]  = flush && (sel == k);
        end
        cnts[0] = cnt0;
        cnts[1] = {1'b0, cnt1};
        cnts[2] = cnt2;
    end

    pipe_stage_buf #(.DATA_W(16), .DEPTH(2), .NOP_VALUE(NOP)) u_d2 (
        .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_data(in_data),
        .in_ready(rdy[0]), .out_valid(vld[0]), .out_data(dat[0]), .out_ready(orr[0]), .count(cnt0));
    pipe_stage_buf #(.DATA_W(16), .DEPTH(1), .NOP_VALUE(NOP)) u_d1 (
        .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_data(in_data),
        .in_ready(rdy[1]), .out_valid(vld[1]), .out_data(dat[1]), .out_ready(orr[1]), .count(cnt1));
    pipe_stage_buf #(.DATA_W(16), .DEPTH(3), .NOP_VALUE(NOP)) u_d3 (
        .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_data(in_data),
        .in_ready(rdy[2]), .out_valid(vld[2]), .out_data(dat[2]), .out_ready(orr[2]), .count(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then advance the model.
    task automatic step(input bit v, input logic [15:0] d, input bit r, input bit f);
        logic        e_rdy, e_vld;
        logic [15:0] e_dat;
        in_valid = v; in_data = d; out_ready = r; flush = f;
        #1;
        e_rdy = (mcnt < dep[sel]) && !f;
        e_vld = (mcnt != 0) && !f;
        e_dat = (mcnt != 0) ? q[0] : NOP;
        chk("in_ready", 32'(rdy[sel]), 32'(e_rdy));
        chk("out_valid", 32'(vld[sel]), 32'(e_vld));
        chk("out_data", 32'(dat[sel]), 32'(e_dat));
        chk("count", 32'(cnts[sel]), 32'(mcnt));
        acc = v && e_rdy;
        if (f) begin
            q.delete();
        end else begin
            if (e_vld && r) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        mcnt = q.size();
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (mcnt != 0 && n < 20) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_bound", 32'(mcnt), 32'd0);
    endtask

    initial begin
        int          sent;
        int          n;
        logic [15:0] d;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(rdy[0]), 32'd1);
        chk("rst_out_valid", 32'(vld[0]), 32'd0);
        chk("rst_out_data", 32'(dat[0]), 32'(NOP));
        chk("rst_count", 32'(cnt0), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // DEPTH=2 streaming, one word per cycle
        sel = 0;
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
        drain();

        // stall: third word held upstream until out_ready rises
        step(1'b1, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0);
        step(1'b1, 16'h000C, 1'b0, 1'b0);
        n = 0;
        while (!acc && n < 10) begin
            step(1'b1, 16'h000C, 1'b1, 1'b0);
            n++;
        end
        chk("stall_accept_bound", 32'(acc), 32'd1);
        drain();

        // flush at count=1 with simultaneous push and pop
        step(1'b1, 16'h0055, 1'b0, 1'b0);
        step(1'b1, 16'h0066, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // asynchronous reset mid-stream at count=2
        step(1'b1, 16'h0077, 1'b0, 1'b0);
        step(1'b1, 16'h0088, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(vld[0]), 32'd0);
        chk("midrst_out_data", 32'(dat[0]), 32'(NOP));
        chk("midrst_count", 32'(cnt0), 32'd0);
        chk("midrst_in_ready", 32'(rdy[0]), 32'd1);
        q.delete();
        mcnt = 0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // DEPTH=3 wrap with random stalls
        sel = 2;
        sent = 0;
        n = 0;
        while (sent < 10 && n < 200) begin
            d = 16'h0100 + 16'(sent);
            step(1'b1, d, 1'($urandom_range(0, 1)), 1'b0);
            if (acc) sent++;
            n++;
        end
        chk("wrap_send_bound", 32'(sent), 32'd10);
        drain();

        // DEPTH=1: accepted every second cycle
        sel = 1;
        sent = 0;
        for (int i = 0; i < 12; i++) begin
            d = 16'h0200 + 16'(sent);
            step(1'b1, d, 1'b1, 1'b0);
            if (acc) sent++;
        end
        chk("d1_accepted", 32'(sent), 32'd6);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline buffer that replaces fixed hold/flush stage registers with a valid/ready-handshaked circular buffer of configurable width and depth. Sits between any two pipeline stages (IF→ID first) and provides stall absorption without a combinational ready path, synchronous flush with bubble insertion, and a NOP value on the output whenever empty. One instance per stage boundary; DATA_W carries the concatenated stage payload, e.g. PC+4 and instruction as 64 bits.

## Interface
- DATA_W, 64, payload width in bits (≥1)
- DEPTH, 2, entries (≥1); DEPTH≥2 required for full throughput
- NOP_VALUE, 0 (DATA_W bits), value driven on out_data when empty
- CNT_W, $clog2(DEPTH+1), derived width of count
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all entries
- in_valid  in  1  upstream offers in_data
- in_data  in  DATA_W  upstream payload
- in_ready  out  1  buffer accepts a word this cycle
- out_valid  out  1  out_data holds a valid entry
- out_data  out  DATA_W  oldest entry, or NOP_VALUE when empty
- out_ready  in  1  downstream consumes out_data this cycle
- count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH×DATA_W array, rd_ptr and wr_ptr in 0..DEPTH-1, occupancy register cnt.
- in_ready = (cnt < DEPTH) && !flush; depends only on state and flush, never on out_ready.
- out_valid = (cnt != 0) && !flush; out_data = mem[rd_ptr] when cnt≠0, else NOP_VALUE.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- push: mem[wr_ptr] ← in_data, wr_ptr advances; pop: rd_ptr advances.
- cnt: +1 push only, −1 pop only, unchanged on both or neither.
- Pointer wrap: DEPTH-1 → 0; DEPTH need not be a power of two.
- flush: cnt, rd_ptr, wr_ptr ← 0; overrides push and pop in the same cycle; in-flight in_data is dropped.
- in_valid while in_ready=0: ignored, no state change. out_ready while out_valid=0: ignored.
- Full with simultaneous pop: in_ready already 0, so no push that cycle (no pass-through); cnt drops to DEPTH-1.
- Empty with push: no bypass; word visible on out_data next cycle.
- Stored data not reset; only control state is reset.

## Timing
- Reset (rst=0, asynchronous): cnt=0, pointers=0 ⇒ in_ready=1, out_valid=0, out_data=NOP_VALUE, count=0; held until rst=1, first push possible on the first rising edge after release.
- Latency in→out: 1 cycle.
- Throughput: DEPTH≥2 sustains 1 word/cycle with out_ready held high; DEPTH=1 gives 1 word per 2 cycles.
- flush effect: combinational on in_ready/out_valid in the flush cycle; state empty from the next edge.
- Reset mid-operation discards all entries immediately; no partial pointer state survives.
- count updates on the edge following the push/pop/flush.

## Structure
- Shared package pipe_pkg: NOP instruction constant (default NOP_VALUE for IF/ID), per-boundary payload widths (IF_ID_W=64 etc.).
- One sub-module: wrap_counter (modulus DEPTH, enable, synchronous clear, async active-low reset) instanced for rd_ptr and wr_ptr.
- No other hierarchy; storage and cnt live in pipe_stage_buf.

## Test plan
- Reset: assert rst=0 mid-stream with cnt=2 → same cycle out_valid=0, out_data=NOP_VALUE, count=0, in_ready=1.
- Streaming, DEPTH=2, out_ready=1, push 0x1..0x8 back-to-back → out_data 0x1..0x8 in order, one per cycle, first one cycle after first push, in_ready never drops.
- Stall: out_ready=0, push 0xA,0xB → count=2, in_ready=0, third word 0xC held upstream; raise out_ready → 0xA, 0xB, 0xC delivered, no loss or duplication.
- Flush with simultaneous push/pop at count=1 → next cycle count=0, out_valid=0, out_data=NOP_VALUE; pushed word never appears.
- Wrap, DEPTH=3: push/pop 10 words with random out_ready stalls → order preserved across pointer wrap, count never exceeds 3.
- DEPTH=1: continuous in_valid, out_ready=1 → accepted every second cycle, in_ready alternates 1/0.
